pipelined_cla_addsub: RTL and testbench
=======================================

# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Operand width is split into equal segments, one per pipeline stage; the carry between segments is registered. Sustains one operation per cycle at higher clock rates than a flat 32-bit lookahead adder. Sits in the datapath between operand registers and the result/flag writeback logic. Reports signed overflow, carry-out and zero flags.

## Interface
- WIDTH, 32: operand/result width; must be divisible by STAGES*4.
- STAGES, 4: pipeline stages; legal values are 1, 2, 4 and 8. Segment width SEG = WIDTH/STAGES.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in.
- Sub  in  1  1 = A − B − !Cin (B inverted; effective carry-in = Cin when Sub=1; Cin=1 gives plain A−B).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference.
- Cout  out  1  carry out of the MSB (for Sub, 1 = no borrow).
- Over  out  1  two's-complement signed overflow.
- Zero  out  1  S == 0.

## Operation
- Effective operand Be = Sub ? ~B : B. The carry-in to segment 0 is Cin in both modes.
- Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] of A and Be using 4-bit lookahead groups plus a second-level lookahead across groups (group P/G). Its carry-out is registered as the carry-in of stage k+1.
- Not-yet-processed operand segments travel alongside in skew registers. Finished result segments travel in de-skew registers so that all of S leaves together.
- Flags are computed in the final stage:
  - Over = (A[MSB] == Be[MSB]) && (S[MSB] != A[MSB]).
  - Cout = carry out of the top segment.
  - Zero = ~|S.
- Each stage holds a valid bit.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage shifts forward, and stage 0 loads the input if in_valid, or a bubble otherwise. When adv=0, all stage registers hold.
- in_ready = adv. A bundle is accepted exactly when in_valid && in_ready.
- Outputs S, Cout, Over and Zero are registered and are stable while out_valid=1 && out_ready=0.
- STAGES=1 gives a single registered full-width lookahead adder with the same handshake.

## Timing
- Reset, asynchronous on reset_n low: all valid bits clear, so out_valid=0. S=0, Cout=0, Over=0, Zero=0.
  - in_ready = 1 during and after reset, because it follows adv and out_valid=0.
  - Data and skew registers clear to 0.
- Latency: a bundle accepted at edge t appears with out_valid=1 after edge t+STAGES, provided there is no stall.
- Throughput: one result per cycle while out_ready=1.
- Back-pressure: if out_valid=1 && out_ready=0, the pipeline freezes and in_ready=0. No bundle is dropped or duplicated, and order is preserved.
- Bubbles: valid bits propagate with the data, so idle cycles produce out_valid=0 slots. Bubbles are not collapsed.
- Simultaneous output pop and input push in the same cycle are both honoured.
- Asserting reset_n low mid-stream discards all in-flight bundles immediately. The first accept after release completes STAGES cycles later.
- There is no combinational path from A, B, Cin or Sub to any output. in_ready depends combinationally on out_ready and out_valid only.

## Test plan
- Add, WIDTH=32, STAGES=4: A=0x7FFFFFFF, B=0x00000001, Cin=0, Sub=0 -> after 4 cycles S=0x80000000, Over=1, Cout=0, Zero=0.
- Subtract: A=5, B=5, Cin=1, Sub=1 -> S=0, Zero=1, Cout=1, Over=0. Then A=3, B=5, Cin=1, Sub=1 -> S=0xFFFFFFFE, Cout=0, Over=0.
- Full carry ripple across every segment: A=0xFFFFFFFF, B=0, Cin=1 -> S=0, Cout=1, Zero=1. Also confirms the registered inter-segment carries.
- Streaming with random back-pressure: 1000 random bundles; out_ready toggles randomly; in_valid is random. Each result must match a reference model in order, with no loss or duplicate, and outputs must be held stable while stalled.
- Reset mid-operation: 3 bundles in flight; pull reset_n low for 1 cycle -> out_valid=0 and flags=0 immediately. The next bundle emerges exactly STAGES cycles after acceptance.
- Parameter sweep: WIDTH ∈ {16, 32, 64} × STAGES ∈ {1, 2, 4} -> latency equals STAGES and results match the model for all corner operands (0, max, min signed, alternating 0xA5…).

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one operand segment per stage, registered
// inter-segment carry, operand skew / result de-skew, global-stall valid/ready handshake.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Over,
    output logic             Zero
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;

    logic              adv;
    logic [STAGES:0]   vld_pipe;

    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    // Level k holds the operand bits not yet added (skew), the finished low result
    // bits (de-skew) and, on top of those, the carry into segment k.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]     a_q, b_q;
        logic [LO:0]       cs_q;
        logic [SEG-1:0]    sum;
        logic              co;
        logic [LO+SEG:0]   cs_nx;

        cla_seg #(.W(SEG)) u_seg (
            .a  (a_q[SEG-1:0]),
            .b  (b_q[SEG-1:0]),
            .ci (cs_q[LO]),
            .s  (sum),
            .co (co)
        );

        assign cs_nx[LO+SEG:LO] = {co, sum};

        if (k == 0) begin : g_first
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    cs_q <= '0;
                end else if (adv) begin
                    a_q  <= A;
                    b_q  <= Sub ? ~B : B;
                    cs_q <= Cin;
                end
            end
        end else begin : g_next
            assign cs_nx[LO-1:0] = cs_q[LO-1:0];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    cs_q <= '0;
                end else if (adv) begin
                    a_q  <= g_stg[k-1].a_q[RW+SEG-1:SEG];
                    b_q  <= g_stg[k-1].b_q[RW+SEG-1:SEG];
                    cs_q <= g_stg[k-1].cs_nx;
                end
            end
        end
    end

    // Flags come from the last stage, whose operand slice still carries both MSBs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            S    <= '0;
            Cout <= 1'b0;
            Over <= 1'b0;
            Zero <= 1'b0;
        end else if (adv) begin
            S    <= g_stg[L].cs_nx[WIDTH-1:0];
            Cout <= g_stg[L].cs_nx[WIDTH];
            Over <= (g_stg[L].a_q[SEG-1] == g_stg[L].b_q[SEG-1]) &&
                    (g_stg[L].sum[SEG-1] != g_stg[L].a_q[SEG-1]);
            Zero <= ~|g_stg[L].cs_nx[WIDTH-1:0];
        end
    end
endmodule

// One segment: 4-bit lookahead groups with a second lookahead level over group P/G.
module cla_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int NG = W / 4;

    logic [W-1:0]  p, g, c;
    logic [NG-1:0] gp, gg;
    logic [NG:0]   gc;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gp = '0;
        gg = '0;
        gc = '0;
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gp[j]   = &p[4*j +: 4];
            gg[j]   = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
                      (&p[4*j+1 +: 3] & g[4*j]);
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                       (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        s  = p ^ c;
        co = gc[NG];
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed and streaming bench for pipelined_cla_addsub: 32b/4-stage main instance plus
// 16b/1-stage and 64b/2-stage instances for the width/depth sweep.
module tb_pipelined_cla_addsub;
    logic        clock = 1'b0;
    logic        reset_n, in_valid, rdy, cin, sub;
    logic [31:0] a, b;
    logic [15:0] a16, b16;
    logic [63:0] a64, b64;

    logic        rdy0, v0, c0, ov0, z0;
    logic [31:0] s0;
    logic        rdy16, v16, c16, ov16, z16;
    logic [15:0] s16;
    logic        rdy64, v64, c64, ov64, z64;
    logic [63:0] s64;

    int          n_chk = 0;
    int          n_pass = 0;
    int          got_lat[3];
    logic [63:0] got_s[3];
    logic [2:0]  got_f[3];

    always #5 clock = ~clock;

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(v0), .out_ready(rdy),
        .S(s0), .Cout(c0), .Over(ov0), .Zero(z0));

    pipelined_cla_addsub #(.WIDTH(16), .STAGES(1)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy16),
        .A(a16), .B(b16), .Cin(cin), .Sub(sub), .out_valid(v16), .out_ready(1'b1),
        .S(s16), .Cout(c16), .Over(ov16), .Zero(z16));

    pipelined_cla_addsub #(.WIDTH(64), .STAGES(2)) dut64 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy64),
        .A(a64), .B(b64), .Cin(cin), .Sub(sub), .out_valid(v64), .out_ready(1'b1),
        .S(s64), .Cout(c64), .Over(ov64), .Zero(z64));

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Reference: {Over, Zero, Cout, S} from plain wide arithmetic.
    function automatic logic [66:0] model(input int w, input logic [63:0] x, y,
                                          input logic ci, su);
        logic [63:0] mask, be, s;
        logic [64:0] sum;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        be   = (su ? ~y : y) & mask;
        sum  = {1'b0, x & mask} + {1'b0, be} + {64'd0, ci};
        s    = sum[63:0] & mask;
        return {(x[w-1] == be[w-1]) && (s[w-1] != x[w-1]), s == 64'd0, sum[w], s};
    endfunction

    function automatic logic [63:0] corner(input int w, input int i);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (i)
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            default: return 64'hA5A5_A5A5_A5A5_A5A5 & mask;
        endcase
    endfunction

    // Called at posedge+1 with empty pipelines; records first result and latency per DUT.
    task automatic push_vec(input logic [31:0] va, vb, input logic vcin, vsub);
        bit seen[3];
        a = va; b = vb; cin = vcin; sub = vsub; rdy = 1'b1; in_valid = 1'b1;
        seen = '{0, 0, 0};
        got_lat = '{0, 0, 0};
        #1 chk("push_ready", rdy0, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clock); #1;
            if (v0 && !seen[0]) begin
                seen[0] = 1; got_lat[0] = n; got_s[0] = {32'd0, s0}; got_f[0] = {ov0, z0, c0};
            end
            if (v16 && !seen[1]) begin
                seen[1] = 1; got_lat[1] = n; got_s[1] = {48'd0, s16}; got_f[1] = {ov16, z16, c16};
            end
            if (v64 && !seen[2]) begin
                seen[2] = 1; got_lat[2] = n; got_s[2] = s64; got_f[2] = {ov64, z64, c64};
            end
        end
    endtask

    task automatic chk_main(input string tag, input logic [31:0] es, input logic eo, ez, ec);
        chk({tag, "_lat"}, got_lat[0], 4);
        chk({tag, "_s"}, got_s[0], {32'd0, es});
        chk({tag, "_flags"}, got_f[0], {eo, ez, ec});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [66:0] q[$];
        logic [66:0] e, held;
        logic        held_v;
        int          sent, rcvd;

        reset_n = 1'b0; in_valid = 1'b0; rdy = 1'b1; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0; a16 = '0; b16 = '0; a64 = '0; b64 = '0;
        #2;
        chk("reset_valid", {v0, v16, v64}, 3'b000);
        chk("reset_out", {ov0, z0, c0, s0}, 35'd0);
        chk("reset_in_ready", rdy0, 1);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // directed, hand-computed
        push_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk_main("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        push_vec(32'd5, 32'd5, 1'b1, 1'b1);
        chk_main("sub_eq", 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        push_vec(32'd3, 32'd5, 1'b1, 1'b1);
        chk_main("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        push_vec(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        chk_main("ripple", 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        push_vec(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        chk_main("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        push_vec(32'd10, 32'd3, 1'b0, 1'b1);
        chk_main("sub_borrow_in", 32'h0000_0006, 1'b0, 1'b0, 1'b1);

        // random streaming with back-pressure
        sent = 0; rcvd = 0; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            if (held_v) chk("stall_hold", {v0, ov0, z0, c0, 32'd0, s0}, {1'b1, held});
            rdy      = 1'($urandom_range(0, 1));
            in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (v0 && rdy) begin
                if (q.size() == 0) chk("stream_spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("stream_res", {ov0, z0, c0, 32'd0, s0}, e);
                end
                rcvd++;
            end
            if (in_valid && rdy0) begin
                q.push_back(model(32, {32'd0, a}, {32'd0, b}, cin, sub));
                sent++;
            end
            held_v = v0 && !rdy;
            held   = {ov0, z0, c0, 32'd0, s0};
            @(posedge clock); #1;
        end
        in_valid = 1'b0; rdy = 1'b1;
        chk("stream_count", rcvd, 1000);
        chk("stream_left", q.size(), 0);
        repeat (6) @(posedge clock);
        #1;

        // back-pressure freeze then reset with bundles in flight
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 32'h7FFF_FFFF + i; b = 32'd1; cin = 1'b0; sub = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("bp_valid", v0, 1);
        chk("bp_in_ready", rdy0, 0);
        chk("bp_s", {ov0, s0}, {1'b1, 32'h8000_0000});
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_out", {ov0, z0, c0, s0}, 35'd0);
        chk("mid_rst_in_ready", rdy0, 1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        push_vec(32'd3, 32'd5, 1'b1, 1'b0);
        chk_main("post_rst", 32'd9, 1'b0, 1'b0, 1'b0);

        // corner sweep across widths and depths
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic vs, vc;
                vs  = 1'((i ^ j) & 1);
                vc  = 1'(j >> 1);
                a16 = 16'(corner(16, i)); b16 = 16'(corner(16, j));
                a64 = corner(64, i);      b64 = corner(64, j);
                push_vec(32'(corner(32, i)), 32'(corner(32, j)), vc, vs);
                chk("sw32_lat", got_lat[0], 4);
                chk("sw32_res", {got_f[0], got_s[0]}, model(32, corner(32, i), corner(32, j), vc, vs));
                chk("sw16_lat", got_lat[1], 1);
                chk("sw16_res", {got_f[1], got_s[1]}, model(16, corner(16, i), corner(16, j), vc, vs));
                chk("sw64_lat", got_lat[2], 2);
                chk("sw64_res", {got_f[2], got_s[2]}, model(64, corner(64, i), corner(64, j), vc, vs));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
